// File: rtl/ppt_sequencer.sv
// ppt_sequencer: pulse sequencer for the PPT controller.
// Generates the thruster `fire` pulse train on a divided time base, using
// configuration latched from the register map at the start of each run.
//
// Ports:
//   clk        system clock (32.768 kHz oscillator in the target build)
//   rst        synchronous active-high reset
//   clk_div    time-base divider: one tick every 2^(clk_div+1) clk cycles
//   period     pulse period in ticks (0 behaves as 1)
//   width      pulse high time in ticks
//   count      pulses per run (0 finishes immediately with no pulse)
//   run_ppt    level-sensitive run request; dropping it aborts a run
//   fire       registered thruster fire pulse
//   count_done completed pulse periods in the current or last run
//   done       set once `count` periods have completed
//   busy       high while a run is in progress
module ppt_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  clk_div,
   input  logic [13:0] period,
   input  logic [13:0] width,
   input  logic [7:0]  count,
   input  logic        run_ppt,
   output logic        fire,
   output logic [7:0]  count_done,
   output logic        done,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_n;
   logic [31:0] presc, presc_n;
   logic [13:0] phase, phase_n;
   logic [4:0]  div_l, div_l_n;
   logic [13:0] period_l, period_l_n;
   logic [13:0] width_l, width_l_n;
   logic [7:0]  count_l, count_l_n;
   logic [7:0]  count_done_n;
   logic        done_n;
   logic        fire_n;

   logic [31:0] tick_max;
   logic        tick;
   logic [13:0] eff_period;
   logic [7:0]  cd_inc;

   // For clk_div=31 the shift wraps to 0 and the subtraction yields
   // 2^32-1, which is exactly the required terminal count.
   always_comb begin
      tick_max   = (32'd2 << div_l) - 32'd1;
      tick       = (presc == tick_max);
      eff_period = (period_l == '0) ? 14'd1 : period_l;
      cd_inc     = count_done + 8'd1;
   end

   always_comb begin
      state_n      = state;
      presc_n      = presc;
      phase_n      = phase;
      div_l_n      = div_l;
      period_l_n   = period_l;
      width_l_n    = width_l;
      count_l_n    = count_l;
      count_done_n = count_done;
      done_n       = done;

      case (state)
         IDLE: begin
            if (run_ppt) begin
               count_done_n = '0;
               if (count != '0) begin
                  state_n    = RUN;
                  div_l_n    = clk_div;
                  period_l_n = period;
                  width_l_n  = width;
                  count_l_n  = count;
                  presc_n    = '0;
                  phase_n    = '0;
                  done_n     = 1'b0;
               end else begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end
            end
         end

         RUN: begin
            // Abort takes priority over a period completing on this edge.
            if (!run_ppt) begin
               state_n = IDLE;
            end else if (tick) begin
               presc_n = '0;
               if (phase == eff_period - 14'd1) begin
                  phase_n      = '0;
                  count_done_n = cd_inc;
                  if (cd_inc == count_l) begin
                     state_n = DONE;
                     done_n  = 1'b1;
                  end
               end else begin
                  phase_n = phase + 14'd1;
               end
            end else begin
               presc_n = presc + 32'd1;
            end
         end

         DONE: begin
            done_n = 1'b1;
            if (!run_ppt) state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase

      // Registered fire is derived from next state/phase/width so it
      // changes on the same edge as the phase that governs it.
      fire_n = (state_n == RUN) && (phase_n < width_l_n);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         presc      <= '0;
         phase      <= '0;
         div_l      <= '0;
         period_l   <= '0;
         width_l    <= '0;
         count_l    <= '0;
         count_done <= '0;
         done       <= 1'b0;
         fire       <= 1'b0;
      end else begin
         state      <= state_n;
         presc      <= presc_n;
         phase      <= phase_n;
         div_l      <= div_l_n;
         period_l   <= period_l_n;
         width_l    <= width_l_n;
         count_l    <= count_l_n;
         count_done <= count_done_n;
         done       <= done_n;
         fire       <= fire_n;
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_ppt_sequencer.sv
// Scoreboard bench for ppt_sequencer: the stimulus process computes expected
// outputs from elapsed time since run start and pushes them; a monitor on
// the falling edge pops and compares against the DUT.
module tb_ppt_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  clk_div;
   logic [13:0] period;
   logic [13:0] width;
   logic [7:0]  count;
   logic        run_ppt;
   logic        fire;
   logic [7:0]  count_done;
   logic        done;
   logic        busy;

   always #5 clk = ~clk;

   ppt_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .clk_div    (clk_div),
      .period     (period),
      .width      (width),
      .count      (count),
      .run_ppt    (run_ppt),
      .fire       (fire),
      .count_done (count_done),
      .done       (done),
      .busy       (busy)
   );

   typedef struct {
      string      tag;
      logic       fire;
      logic       busy;
      logic       done;
      logic [7:0] cd;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   exp_t        push_e;
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   string       cur_tag  = "reset";

   // Reference model: tracks elapsed cycles since a run started and derives
   // outputs with plain division/modulo over the pulse period in cycles.
   typedef enum {M_IDLE, M_RUN, M_DONE} mmode_t;
   mmode_t          m_mode = M_IDLE;
   longint unsigned m_t, m_tick, m_per, m_wid, m_cnt;
   logic            m_fire = 1'b0, m_busy = 1'b0, m_done = 1'b0;
   logic [7:0]      m_cd = '0;

   task automatic model_step();
      longint unsigned cyc, k;
      if (rst) begin
         m_mode = M_IDLE;
         m_fire = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_cd = '0;
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (run_ppt) begin
                  m_cd = '0;
                  if (count != 0) begin
                     m_tick = 64'd1 << (int'(clk_div) + 1);
                     m_per  = (period == 0) ? 64'd1 : 64'(period);
                     m_wid  = 64'(width);
                     m_cnt  = 64'(count);
                     m_t    = 0;
                     m_mode = M_RUN;
                     m_busy = 1'b1;
                     m_fire = (width != 0);
                     m_done = 1'b0;
                  end else begin
                     m_mode = M_DONE;
                     m_busy = 1'b0;
                     m_fire = 1'b0;
                     m_done = 1'b1;
                  end
               end
            end
            M_RUN: begin
               if (!run_ppt) begin
                  m_mode = M_IDLE;
                  m_fire = 1'b0;
                  m_busy = 1'b0;
               end else begin
                  m_t = m_t + 1;
                  cyc = m_tick * m_per;
                  k   = m_t / cyc;
                  if (k >= m_cnt) begin
                     m_mode = M_DONE;
                     m_cd   = m_cnt[7:0];
                     m_done = 1'b1;
                     m_fire = 1'b0;
                     m_busy = 1'b0;
                  end else begin
                     m_cd   = k[7:0];
                     m_fire = (m_t % cyc) < (m_wid * m_tick);
                  end
               end
            end
            M_DONE: begin
               if (!run_ppt) m_mode = M_IDLE;
            end
         endcase
      end
   endtask

   // One clock: predict, let the edge happen, record the prediction, move
   // off the edge before the caller drives new inputs.
   task automatic step();
      model_step();
      @(posedge clk);
      push_e.tag  = cur_tag;
      push_e.fire = m_fire;
      push_e.busy = m_busy;
      push_e.done = m_done;
      push_e.cd   = m_cd;
      sb.push_back(push_e);
      #1;
   endtask

   task automatic set_cfg(input int d, input int p, input int w, input int c);
      clk_div = 5'(d);
      period  = 14'(p);
      width   = 14'(w);
      count   = 8'(c);
   endtask

   task automatic run_for(input int unsigned n);
      run_ppt = 1'b1;
      repeat (n) step();
   endtask

   task automatic idle_for(input int unsigned n);
      run_ppt = 1'b0;
      repeat (n) step();
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         n_checks++;
         if (fire === mon_e.fire && busy === mon_e.busy &&
             done === mon_e.done && count_done === mon_e.cd) begin
            n_pass++;
         end else begin
            $display("FAIL %s t=%0t: got fire=%0b busy=%0b done=%0b count_done=%0d, expected fire=%0b busy=%0b done=%0b count_done=%0d",
                     mon_e.tag, $time, fire, busy, done, count_done,
                     mon_e.fire, mon_e.busy, mon_e.done, mon_e.cd);
         end
      end
   end

   initial begin
      rst = 1'b1;
      run_ppt = 1'b0;
      set_cfg(0, 4, 1, 3);
      cur_tag = "reset";
      repeat (2) step();
      rst = 1'b0;
      idle_for(2);

      cur_tag = "basic";
      set_cfg(0, 4, 1, 3);
      run_for(30);
      idle_for(2);

      cur_tag = "period0";
      set_cfg(0, 0, 1, 2);
      run_for(8);
      idle_for(2);

      cur_tag = "width0";
      set_cfg(0, 3, 0, 1);
      run_for(10);
      idle_for(2);

      cur_tag = "count0";
      set_cfg(0, 4, 1, 0);
      run_for(4);
      idle_for(2);

      cur_tag = "wide";
      set_cfg(1, 2, 5, 2);
      run_for(20);
      idle_for(2);

      cur_tag = "abort";
      set_cfg(0, 4, 1, 5);
      run_for(10);
      idle_for(3);
      cur_tag = "restart";
      run_for(12);
      idle_for(2);

      cur_tag = "midchange";
      set_cfg(0, 4, 2, 3);
      run_ppt = 1'b1;
      step();
      for (int i = 0; i < 30; i++) begin
         period = 14'($urandom_range(0, 9));
         width  = 14'($urandom_range(0, 9));
         count  = 8'($urandom_range(0, 9));
         clk_div = 5'($urandom_range(0, 3));
         step();
      end
      idle_for(2);

      cur_tag = "rst_in_run";
      set_cfg(0, 4, 2, 3);
      run_for(2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle_for(2);

      cur_tag = "div9";
      set_cfg(9, 4, 1, 2);
      run_for(8200);
      idle_for(2);

      cur_tag = "div31";
      set_cfg(31, 3, 1, 1);
      run_for(40);
      idle_for(2);

      cur_tag = "random";
      for (int r = 0; r < 150; r++) begin
         int unsigned d, p, c, full;
         d = $urandom_range(0, 2);
         p = $urandom_range(0, 6);
         c = $urandom_range(0, 4);
         set_cfg(int'(d), int'(p), int'($urandom_range(0, 7)), int'(c));
         full = c * ((p == 0) ? 1 : p) * (2 << d) + 3;
         run_for($urandom_range(1, full));
         if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
         end
         idle_for($urandom_range(1, 3));
      end

      repeat (3) @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ppt_sequencer.md
# ppt_sequencer

Pulse sequencer for the PPT (pulsed plasma thruster) controller. It sits between the I2C register map and the thruster firing output.

- Consumes the configuration fields: clock divider, period, width, count and run.
- Generates the `fire` pulse train on a divided time base.
- Reports `count_done` and `done` back to the register map for readback.

## Interface

Parameters:
- none; all widths are fixed by the register map layout.

Ports:
- `clk`  in  1  system clock; the 32.768 kHz oscillator in the target build.
- `rst`  in  1  reset; synchronous, active-high.
- `clk_div`  in  5  time-base divider; one tick every 2^(clk_div+1) `clk` cycles.
- `period`  in  14  pulse period, in ticks.
- `width`  in  14  pulse high time, in ticks.
- `count`  in  8  number of pulses per run.
- `run_ppt`  in  1  run request, level-sensitive.
- `fire`  out  1  thruster fire pulse, registered.
- `count_done`  out  8  number of completed pulse periods in the current or last run.
- `done`  out  1  high once `count` periods have completed.
- `busy`  out  1  high while in state RUN.

## Operation

- **States:** IDLE, RUN, DONE. Reset enters IDLE.
- **Reset values:** `fire`=0, `count_done`=0, `done`=0, `busy`=0. The prescaler, phase and latched parameters are all cleared.
- **IDLE:**
  - `run_ppt`=1 and `count`≠0 → latch `clk_div`, `period`, `width` and `count`; clear prescaler, phase, `count_done` and `done`; go to RUN.
  - `run_ppt`=1 and `count`=0 → clear `count_done`; set `done`; go to DONE with no pulse.
- **RUN:**
  - The 32-bit prescaler increments every cycle.
  - A tick occurs when prescaler = 2^(latched clk_div+1)−1; the prescaler then returns to 0.
  - 14-bit phase increments on each tick.
  - On a tick with phase = eff_period−1: phase←0 and `count_done`←`count_done`+1.
  - If that makes `count_done` equal the latched count: go to DONE and set `done`.
- **eff_period:** equals `period`, except `period`=0 is treated as 1.
- **fire:**
  - Next value is 1 iff the next state is RUN and next phase < latched width.
  - `width`=0 → `fire` never asserts, but periods are still counted.
  - `width` ≥ eff_period → `fire` stays high for the whole run.
- **DONE:**
  - `fire`=0 and `done`=1; `count_done` holds.
  - `run_ppt`=0 → IDLE, with `done` and `count_done` held for readback.
  - A new run from IDLE clears both.
- **Abort:**
  - `run_ppt`=0 while in RUN → IDLE on the next edge.
  - `fire` drops in that same edge; `done` stays 0; `count_done` holds the partial count.
- **Parameter changes:** input changes during RUN or DONE are ignored. Parameters are re-latched only on an IDLE→RUN start.
- **Restart:** because `run_ppt` is level-sensitive, the only path to a new run is DONE→IDLE (via `run_ppt`=0), then IDLE→RUN.
- **Priority:** `rst` overrides everything. Abort overrides a period completion in the same cycle, so the count is not incremented.

## Timing

- **Start:** `run_ppt` sampled high in IDLE at edge N → `busy`=1 and `fire`=1 (when `width`>0) from edge N.
- **Tick spacing:** one tick every 2^(clk_div+1) cycles; the first tick lands at edge N+2^(clk_div+1).
- **Pulse timing:**
  - `fire` high for `width`×2^(clk_div+1) cycles.
  - Pulse starts every eff_period×2^(clk_div+1) cycles.
- **Completion:** `count_done` increments, and on the last period `done` rises and `fire`/`busy` fall, at edge N+k×eff_period×2^(clk_div+1).
- **Abort latency:** `run_ppt` low at edge M → `fire`=0 and `busy`=0 after edge M.
- **Default config:** `clk_div`=9, `period`=128, `width`=1, `count`=16 with a 32.768 kHz clock gives:
  - 32 Hz ticks;
  - a 31.25 ms pulse every 4 s;
  - `done` after 64 s.

## Test plan

- **Basic run:** `clk_div`=0, `period`=4, `width`=1, `count`=3, `run_ppt`=1 at edge N → expect:
  - `fire` high for 2 cycles starting at edges N, N+8, N+16;
  - `count_done` = 1/2/3 at N+8/N+16/N+24;
  - `done`=1 and `busy`=0 at N+24.
- **Edge cases, `clk_div`=0:**
  - `period`=0, `width`=1, `count`=2 → pulse every 2 cycles, `fire` continuously high, `done` at N+4.
  - `width`=0, `period`=3, `count`=1 → `fire` never high, `done` at N+6.
  - `count`=0 → `done`=1 at the edge after `run_ppt` is sampled, with no `fire`.
- **Abort:** `period`=4, `count`=5, `run_ppt` dropped at edge N+10 → expect:
  - `fire`=0 and `busy`=0 after N+10;
  - `count_done`=1 and `done`=0;
  - reasserting `run_ppt` clears `count_done` and restarts.
- **Mid-run change:** change `width`/`period` mid-run → pulse timing is unchanged until the next IDLE→RUN start.
- **Reset:** assert `rst` during RUN with `fire`=1 → after the next edge all outputs are 0 and the state is IDLE.
- **Default config:** `clk_div`=9, `period`=128, `width`=1, `count`=16 → expect:
  - `fire` high for 1024 cycles;
  - 131072-cycle spacing between pulse starts;
  - `done` after 2097152 cycles.
